// File: rtl/pkt_capture.sv
// Ingress capture stage: writes MAC frames into the show-ahead FIFO and issues
// one descriptor per packet to the DMA write controller.
module pkt_capture #(
   parameter logic [31:0] BUF_BASE   = 32'h0000_0000,
   parameter logic [31:0] BUF_BYTES  = 32'h0010_0000,
   parameter int unsigned SNAP_WORDS = 384,
   parameter int unsigned FIFO_DEPTH = 512
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sop,
   input  logic        in_eop,
   input  logic [1:0]  in_empty,
   output logic [31:0] fifo_data,
   output logic        fifo_wrreq,
   input  logic [8:0]  fifo_usedw,
   input  logic        fifo_full,
   output logic        wr_ctrl,
   input  logic        wr_ctrl_rdy,
   output logic [31:0] control,
   output logic [31:0] pkt_begin,
   output logic [31:0] pkt_end,
   output logic [31:0] write_address,
   output logic [31:0] pkt_count,
   output logic [31:0] drop_count
);

   localparam int unsigned WCNT_W  = 10;
   localparam int unsigned FREE_W  = 11;
   localparam int unsigned BYTE_W  = 16;
   localparam logic [WCNT_W-1:0] SNAP_LIM  = WCNT_W'(SNAP_WORDS);
   localparam logic [FREE_W-1:0] SNAP_FREE = FREE_W'(SNAP_WORDS);
   localparam logic [32:0]       SNAP_SPAN = 33'(SNAP_WORDS * 4);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_DROP,
      S_ISSUE,
      S_WAIT_RDY
   } state_e;

   state_e state_q, state_d;

   logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
   logic              trunc_q, trunc_d;
   logic              err_q, err_d;
   logic [31:0]       wr_offset_q, wr_offset_d;
   logic              wr_ctrl_q, wr_ctrl_d;
   logic [31:0]       control_q, control_d;
   logic [31:0]       pkt_end_q, pkt_end_d;
   logic [31:0]       write_address_q, write_address_d;
   logic [31:0]       pkt_count_q, pkt_count_d;
   logic [31:0]       drop_count_q, drop_count_d;

   logic [FREE_W-1:0] fifo_free;
   logic              has_room;
   logic              accept;
   logic [2:0]        beat_bytes;
   logic [BYTE_W:0]   byte_sum;
   logic [BYTE_W-1:0] byte_sat;
   logic [31:0]       pkt_span;
   logic [31:0]       off_sum;
   logic              off_wrap;

   // Room is judged once at SOP; a full FIFO never admits a write.
   assign fifo_free  = FREE_W'(FIFO_DEPTH) - FREE_W'(fifo_usedw);
   assign has_room   = !fifo_full && (fifo_free >= SNAP_FREE);
   assign accept     = in_valid && in_ready;
   assign beat_bytes = in_eop ? (3'd4 - {1'b0, in_empty}) : 3'd4;
   assign byte_sum   = (BYTE_W+1)'(byte_cnt_q) + (BYTE_W+1)'(beat_bytes);
   assign byte_sat   = byte_sum[BYTE_W] ? {BYTE_W{1'b1}} : byte_sum[BYTE_W-1:0];

   // Ring advance: 64-byte aligned, and wrap early if a full snap would not fit.
   assign pkt_span = (pkt_end_q + 32'd63) & ~32'd63;
   assign off_sum  = wr_offset_q + pkt_span;
   assign off_wrap = (33'(off_sum) + SNAP_SPAN) > 33'(BUF_BYTES);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept && in_sop && enable) begin
               if (has_room) begin
                  state_d = in_eop ? S_ISSUE : S_CAPTURE;
               end else if (!in_eop) begin
                  state_d = S_DROP;
               end
            end
         end
         S_CAPTURE: begin
            if (accept && (in_sop || in_eop)) begin
               state_d = S_ISSUE;
            end
         end
         S_DROP: begin
            if (accept && in_eop) begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT_RDY;
         end
         S_WAIT_RDY: begin
            if (wr_ctrl_rdy) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Handshake and FIFO strobe follow the stream in the same cycle; forced low in reset.
   always_comb begin
      in_ready   = 1'b0;
      fifo_wrreq = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_ready   = 1'b1;
            fifo_wrreq = in_valid && in_sop && enable && has_room;
         end
         S_CAPTURE: begin
            in_ready   = !fifo_full;
            fifo_wrreq = in_valid && !fifo_full && !in_sop && (word_cnt_q < SNAP_LIM);
         end
         S_DROP: begin
            in_ready = 1'b1;
         end
         default: begin
            in_ready   = 1'b0;
            fifo_wrreq = 1'b0;
         end
      endcase
      if (!reset) begin
         in_ready   = 1'b0;
         fifo_wrreq = 1'b0;
      end
      fifo_data = fifo_wrreq ? in_data : 32'd0;
   end

   always_comb begin
      word_cnt_d      = word_cnt_q;
      byte_cnt_d      = byte_cnt_q;
      trunc_d         = trunc_q;
      err_d           = err_q;
      wr_offset_d     = wr_offset_q;
      wr_ctrl_d       = 1'b0;
      control_d       = control_q;
      pkt_end_d       = pkt_end_q;
      write_address_d = write_address_q;
      pkt_count_d     = pkt_count_q;
      drop_count_d    = drop_count_q;

      unique case (state_q)
         S_IDLE: begin
            if (fifo_wrreq) begin
               word_cnt_d = WCNT_W'(1);
               byte_cnt_d = BYTE_W'(beat_bytes);
               trunc_d    = 1'b0;
               err_d      = 1'b0;
            end
            if (accept && in_sop && enable && !has_room) begin
               drop_count_d = drop_count_q + 32'd1;
            end
         end
         S_CAPTURE: begin
            if (accept) begin
               if (in_sop) begin
                  err_d = 1'b1;
               end else begin
                  byte_cnt_d = byte_sat;
                  if (word_cnt_q < SNAP_LIM) begin
                     word_cnt_d = word_cnt_q + WCNT_W'(1);
                  end else begin
                     trunc_d = 1'b1;
                  end
               end
            end
         end
         S_WAIT_RDY: begin
            if (wr_ctrl_rdy) begin
               wr_offset_d = off_wrap ? 32'd0 : off_sum;
            end
         end
         default: begin
         end
      endcase

      // Descriptor fields are latched on entry so they are valid with the pulse.
      if (state_d == S_ISSUE) begin
         wr_ctrl_d       = 1'b1;
         control_d       = {14'd0, err_d, trunc_d, byte_cnt_d};
         pkt_end_d       = 32'(word_cnt_d) << 2;
         write_address_d = BUF_BASE + wr_offset_q;
         pkt_count_d     = pkt_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_cnt_q      <= '0;
         byte_cnt_q      <= '0;
         trunc_q         <= 1'b0;
         err_q           <= 1'b0;
         wr_offset_q     <= '0;
         wr_ctrl_q       <= 1'b0;
         control_q       <= '0;
         pkt_end_q       <= '0;
         write_address_q <= '0;
         pkt_count_q     <= '0;
         drop_count_q    <= '0;
      end else begin
         word_cnt_q      <= word_cnt_d;
         byte_cnt_q      <= byte_cnt_d;
         trunc_q         <= trunc_d;
         err_q           <= err_d;
         wr_offset_q     <= wr_offset_d;
         wr_ctrl_q       <= wr_ctrl_d;
         control_q       <= control_d;
         pkt_end_q       <= pkt_end_d;
         write_address_q <= write_address_d;
         pkt_count_q     <= pkt_count_d;
         drop_count_q    <= drop_count_d;
      end
   end

   assign wr_ctrl       = wr_ctrl_q;
   assign control       = control_q;
   assign pkt_begin     = 32'd0;
   assign pkt_end       = pkt_end_q;
   assign write_address = write_address_q;
   assign pkt_count     = pkt_count_q;
   assign drop_count    = drop_count_q;

endmodule
